// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Multi-cycle data-memory controller placed behind the MEM stage. Each
//   32-bit load/store is split into two half-word accesses on a 16-bit
//   asynchronous SRAM: low half first, then high half. Each half is held on
//   the pins for WAIT_CYCLES+1 cycles. While an access is in flight, ready is
//   low so that the hazard logic can freeze the pipeline.
//
//   Optional build macro: SRAM_RDBUF_EN
//     Adds a one-entry read buffer. A load that hits the buffered word
//     completes without touching the SRAM.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rd_en, wr_en      load / store request (a store wins if both are set)
//   address           CPU byte address (ALU result)
//   write_data        store data (Rm)
//   read_data         registered load result
//   ready             low while a request is pending (pipeline freeze)
//   sram_addr         half-word address
//   sram_dq_out/_oe   write half-word and tristate drive enable
//   sram_dq_in        read half-word from the pad
//   sram_we_n/oe_n/ce_n/ub_n/lb_n   active-low SRAM strobes (registered)
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic                   op_wr_q;
    logic [SRAM_ADDR_W-1:0] lo_addr_q;
    logic [15:0]            data_hi_q;
    logic [31:0]            read_data_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic [15:0]            dq_out_q;
    logic                   dq_oe_q;
    logic                   we_n_q, oe_n_q, ce_n_q, ub_n_q, lb_n_q;

    // Byte offset from the SRAM window; wraps mod 2^32 and aliases beyond
    // the SRAM size since only the low SRAM_ADDR_W half-word bits survive.
    logic [31:0]            off;
    logic [30:0]            hw_full;
    logic [SRAM_ADDR_W-1:0] lo_addr_d;
    logic                   req;
    logic                   buf_hit;
    logic                   unused_off;

    assign off        = address - 32'(BASE_ADDR);
    assign hw_full    = {off[31:2], 1'b0};
    assign lo_addr_d  = hw_full[SRAM_ADDR_W-1:0];
    assign unused_off = ^{off[1:0], hw_full};
    assign req        = rd_en | wr_en;

`ifdef SRAM_RDBUF_EN
    logic        buf_valid_q;
    logic [29:0] buf_word_q;
    logic [31:0] buf_data_q;
    logic [29:0] word_q;

    assign buf_hit = rd_en && !wr_en && buf_valid_q && (buf_word_q == off[31:2]);
`else
    assign buf_hit = 1'b0;
`endif

    assign ready = !((state_q == ACC_LO) || (state_q == ACC_HI) ||
                     ((state_q == IDLE) && req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            lo_addr_q   <= '0;
            data_hi_q   <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
`ifdef SRAM_RDBUF_EN
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
            word_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        op_wr_q   <= wr_en;
                        lo_addr_q <= lo_addr_d;
                        data_hi_q <= write_data[31:16];
                        cnt_q     <= '0;
`ifdef SRAM_RDBUF_EN
                        word_q <= off[31:2];
                        if (wr_en && (buf_word_q == off[31:2]))
                            buf_valid_q <= 1'b0;
`endif
                        if (buf_hit) begin
`ifdef SRAM_RDBUF_EN
                            read_data_q <= buf_data_q;
`endif
                            state_q <= DONE;
                        end else begin
                            // Pins are registered, so the low-half drive is
                            // loaded here to be valid throughout ACC_LO.
                            state_q     <= ACC_LO;
                            sram_addr_q <= lo_addr_d;
                            ce_n_q      <= 1'b0;
                            ub_n_q      <= 1'b0;
                            lb_n_q      <= 1'b0;
                            we_n_q      <= !wr_en;
                            oe_n_q      <= wr_en;
                            dq_oe_q     <= wr_en;
                            if (wr_en)
                                dq_out_q <= write_data[15:0];
                        end
                    end
                end
                ACC_LO: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q       <= '0;
                        state_q     <= ACC_HI;
                        sram_addr_q <= lo_addr_q | SRAM_ADDR_W'(1);
                        if (op_wr_q)
                            dq_out_q <= data_hi_q;
                        else
                            read_data_q[15:0] <= sram_dq_in;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ACC_HI: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        ce_n_q  <= 1'b1;
                        ub_n_q  <= 1'b1;
                        lb_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!op_wr_q) begin
                            read_data_q[31:16] <= sram_dq_in;
`ifdef SRAM_RDBUF_EN
                            buf_valid_q <= 1'b1;
                            buf_word_q  <= word_q;
                            buf_data_q  <= {sram_dq_in, read_data_q[15:0]};
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: three instances (WAIT_CYCLES = 1, 0, 3),
// each with a simple behavioural SRAM. Index 0 is the main instance.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en [3];
    logic        wr_en [3];
    logic [31:0] address    = '0;
    logic [31:0] write_data = '0;

    logic [31:0] read_data [3];
    logic        ready     [3];
    logic [17:0] s_addr    [3];
    logic [15:0] dq_out    [3];
    logic        dq_oe     [3];
    logic [15:0] dq_in     [3];
    logic        we_n      [3];
    logic        oe_n      [3];
    logic        ce_n      [3];
    logic        ub_n      [3];
    logic        lb_n      [3];

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_ADDR_W(18)) u_w1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address), .write_data(write_data), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(s_addr[0]), .sram_dq_out(dq_out[0]),
        .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]), .sram_we_n(we_n[0]),
        .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]));

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0), .SRAM_ADDR_W(18)) u_w0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address), .write_data(write_data), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(s_addr[1]), .sram_dq_out(dq_out[1]),
        .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]), .sram_we_n(we_n[1]),
        .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]));

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3), .SRAM_ADDR_W(18)) u_w3 (
        .clk(clk), .rst(rst), .rd_en(rd_en[2]), .wr_en(wr_en[2]),
        .address(address), .write_data(write_data), .read_data(read_data[2]),
        .ready(ready[2]), .sram_addr(s_addr[2]), .sram_dq_out(dq_out[2]),
        .sram_dq_oe(dq_oe[2]), .sram_dq_in(dq_in[2]), .sram_we_n(we_n[2]),
        .sram_oe_n(oe_n[2]), .sram_ce_n(ce_n[2]), .sram_ub_n(ub_n[2]), .sram_lb_n(lb_n[2]));

    for (genvar g = 0; g < 3; g++) begin : g_sram
        bit [15:0] mem [0:(1<<18)-1];
        always @(posedge clk)
            if (!ce_n[g] && !we_n[g] && dq_oe[g])
                mem[s_addr[g]] <= dq_out[g];
        assign dq_in[g] = (!ce_n[g] && !oe_n[g]) ? mem[s_addr[g]] : 16'h0000;
    end

`ifdef SRAM_RDBUF_EN
    localparam int HIT_LOWS = 1;
    localparam int HIT_CES  = 0;
`else
    localparam int HIT_LOWS = 5;
    localparam int HIT_CES  = 4;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          lows;
        int          ces;
        logic [17:0] first_a;
        logic [17:0] last_a;
        bit          saw_we;
        bit          saw_oe;
        bit          timeout;
        logic [31:0] rdata;
    } res_t;

    // Called at a negedge with the DUT in IDLE. Holds the request until
    // ready rises (the DONE cycle), then drops it, as the frozen pipeline would.
    task automatic run_access(input int d, input bit wr, input bit rd,
                              input logic [31:0] a, input logic [31:0] wd,
                              output res_t r);
        r = '{lows: 0, ces: 0, first_a: '0, last_a: '0, saw_we: 0, saw_oe: 0,
              timeout: 1, rdata: '0};
        address = a; write_data = wd; wr_en[d] = wr; rd_en[d] = rd;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (ready[d]) begin
                r.rdata = read_data[d];
                r.timeout = 0;
                wr_en[d] = 1'b0; rd_en[d] = 1'b0;
                break;
            end
            r.lows++;
            if (!ce_n[d]) begin
                if (r.ces == 0) r.first_a = s_addr[d];
                r.last_a = s_addr[d];
                r.ces++;
                if (!we_n[d]) r.saw_we = 1;
                if (dq_oe[d]) r.saw_oe = 1;
            end
            @(negedge clk);
        end
        wr_en[d] = 1'b0; rd_en[d] = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_lo;
        logic [17:0] exp_hi;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [8];
    res_t        r;
    logic [11:0] rdy_pat;
    logic [31:0] rd_mid, rd_end;

    initial begin
        for (int i = 0; i < 3; i++) begin rd_en[i] = 1'b0; wr_en[i] = 1'b0; end

        vecs[0] = '{1, 0, 32'd1024, 32'hDEADBEEF, 18'h00000, 18'h00001, 32'h00000000};
        vecs[1] = '{0, 1, 32'd1024, 32'h0,        18'h00000, 18'h00001, 32'hDEADBEEF};
        vecs[2] = '{1, 0, 32'd1032, 32'hCAFEF00D, 18'h00004, 18'h00005, 32'hDEADBEEF};
        vecs[3] = '{1, 0, 32'd1020, 32'h0BADC0DE, 18'h3FFFE, 18'h3FFFF, 32'hDEADBEEF};
        vecs[4] = '{0, 1, 32'd1032, 32'h0,        18'h00004, 18'h00005, 32'hCAFEF00D};
        vecs[5] = '{0, 1, 32'd1020, 32'h0,        18'h3FFFE, 18'h3FFFF, 32'h0BADC0DE};
        vecs[6] = '{1, 1, 32'd1028, 32'h12345678, 18'h00002, 18'h00003, 32'h0BADC0DE};
        vecs[7] = '{0, 1, 32'd1028, 32'h0,        18'h00002, 18'h00003, 32'h12345678};

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_ctrl", {we_n[0], oe_n[0], ce_n[0], ub_n[0], lb_n[0]}, 5'b11111);
        check("por_dq_oe", dq_oe[0], 1'b0);
        check("por_addr", s_addr[0], 18'h0);
        check("por_dq_out", dq_out[0], 16'h0);
        check("por_rdata", read_data[0], 32'h0);
        check("por_ready", {ready[0], ready[1], ready[2]}, 3'b111);
        @(negedge clk);

        // Table: WAIT_CYCLES = 1 -> ready low in the accepting IDLE cycle
        // plus 4 pin-active cycles, then high in DONE.
        for (int i = 0; i < 8; i++) begin
            run_access(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, r);
            check($sformatf("v%0d_timeout", i), r.timeout, 1'b0);
            check($sformatf("v%0d_lows", i), r.lows, 5);
            check($sformatf("v%0d_ces", i), r.ces, 4);
            check($sformatf("v%0d_lo_addr", i), r.first_a, vecs[i].exp_lo);
            check($sformatf("v%0d_hi_addr", i), r.last_a, vecs[i].exp_hi);
            check($sformatf("v%0d_we", i), r.saw_we, vecs[i].wr);
            check($sformatf("v%0d_dq_oe", i), r.saw_oe, vecs[i].wr);
            check($sformatf("v%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
        end
        check("mem0", g_sram[0].mem[0], 16'hBEEF);
        check("mem1", g_sram[0].mem[1], 16'hDEAD);
        check("mem4", g_sram[0].mem[4], 16'hF00D);
        check("mem5", g_sram[0].mem[5], 16'hCAFE);
        check("mem3fffe", g_sram[0].mem[18'h3FFFE], 16'hC0DE);
        check("mem3ffff", g_sram[0].mem[18'h3FFFF], 16'h0BAD);
        check("mem2", g_sram[0].mem[2], 16'h5678);
        check("mem3", g_sram[0].mem[3], 16'h1234);

        // Back-to-back loads: next instruction's load is present in DONE.
        address = 32'd1032; rd_en[0] = 1'b1; rdy_pat = '0; rd_mid = '0; rd_end = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            rdy_pat[c] = ready[0];
            if (c == 5) begin rd_mid = read_data[0]; address = 32'd1028; end
            if (c == 11) begin rd_end = read_data[0]; rd_en[0] = 1'b0; end
            @(negedge clk);
        end
        rd_en[0] = 1'b0;
        check("b2b_ready_pattern", rdy_pat, 12'h820);
        check("b2b_first", rd_mid, 32'hCAFEF00D);
        check("b2b_second", rd_end, 32'h12345678);
        @(negedge clk);

        // Read buffer sequence (full access expected when built without it)
        run_access(0, 0, 1, 32'd1024, 32'h0, r);
        check("rb1_lows", r.lows, 5);
        check("rb1_rdata", r.rdata, 32'hDEADBEEF);
        run_access(0, 0, 1, 32'd1024, 32'h0, r);
        check("rb2_timeout", r.timeout, 1'b0);
        check("rb2_lows", r.lows, HIT_LOWS);
        check("rb2_ces", r.ces, HIT_CES);
        check("rb2_rdata", r.rdata, 32'hDEADBEEF);
        run_access(0, 1, 0, 32'd1024, 32'h600DF00D, r);
        check("rb3_lows", r.lows, 5);
        check("rb3_rdata", r.rdata, 32'hDEADBEEF);
        run_access(0, 0, 1, 32'd1024, 32'h0, r);
        check("rb4_lows", r.lows, 5);
        check("rb4_ces", r.ces, 4);
        check("rb4_rdata", r.rdata, 32'h600DF00D);

        // Reset in the middle of a write (first ACC_LO cycle)
        address = 32'd1040; write_data = 32'h11112222; wr_en[0] = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_in_acc", ce_n[0], 1'b0);
        rst = 1'b1; wr_en[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ctrl", {we_n[0], oe_n[0], ce_n[0], ub_n[0], lb_n[0]}, 5'b11111);
        check("mid_rst_dq_oe", dq_oe[0], 1'b0);
        check("mid_rst_rdata", read_data[0], 32'h0);
        check("mid_rst_ready", ready[0], 1'b1);
        @(negedge clk);
        #1;
        check("mid_rst_idle_ce", ce_n[0], 1'b1);
        check("mid_rst_no_hi_write", g_sram[0].mem[9], 16'h0000);
        @(negedge clk);
        // Reset also empties the read buffer: full access again.
        run_access(0, 0, 1, 32'd1024, 32'h0, r);
        check("post_rst_lows", r.lows, 5);
        check("post_rst_rdata", r.rdata, 32'h600DF00D);

        // Latency sweep
        run_access(1, 1, 0, 32'd1024, 32'hA5A55A5A, r);
        check("w0_wr_lows", r.lows, 3);
        check("w0_wr_ces", r.ces, 2);
        check("w0_wr_hi_addr", r.last_a, 18'h00001);
        run_access(1, 0, 1, 32'd1024, 32'h0, r);
        check("w0_rd_lows", r.lows, 3);
        check("w0_rd_rdata", r.rdata, 32'hA5A55A5A);
        run_access(2, 1, 0, 32'd1032, 32'h3C3CC3C3, r);
        check("w3_wr_lows", r.lows, 9);
        check("w3_wr_ces", r.ces, 8);
        check("w3_wr_lo_addr", r.first_a, 18'h00004);
        run_access(2, 0, 1, 32'd1032, 32'h0, r);
        check("w3_rd_lows", r.lows, 9);
        check("w3_rd_rdata", r.rdata, 32'h3C3CC3C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
